// File: rtl/ex8_light_sequencer_pkg.sv
// Shared types and constants for the start-lights sequencer and its delay-timer link.
package ex8_light_sequencer_pkg;

  localparam int unsigned DELAY_W = 14;
  localparam int unsigned CNT_W   = 4;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    STEP       = 3'd1,
    STEP_REARM = 3'd2,
    RAND_REARM = 3'd3,
    RAND       = 3'd4
  } state_t;

  // A zero hold would make the timer's N-1 terminal count underflow.
  function automatic logic [DELAY_W-1:0] clamp_hold(input logic [DELAY_W-1:0] n);
    return (n == '0) ? DELAY_W'(1) : n;
  endfunction

endpackage

// File: rtl/ex8_light_sequencer_if.sv
// Trigger/N/time_out handshake between the sequencer (master) and a delay timer (slave).
interface ex8_light_sequencer_if;
  import ex8_light_sequencer_pkg::*;

  logic [DELAY_W-1:0] n;
  logic               trigger;
  logic               time_out;

  modport master (output n, output trigger, input time_out);
  modport slave  (input n, input trigger, output time_out);

endinterface

// File: rtl/ex8_light_sequencer.sv
// Start-lights sequencer: one light per STEP_N timer interval, random hold, then all off with done.
module ex8_light_sequencer
  import ex8_light_sequencer_pkg::*;
#(
  parameter logic [DELAY_W-1:0] STEP_N     = 14'd500,
  parameter int unsigned        NUM_LIGHTS = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [DELAY_W-1:0]           rand_n,
  ex8_light_sequencer_if.master        delay,
  output logic [NUM_LIGHTS-1:0]        lights,
  output logic                         busy,
  output logic                         done
);

  state_t              state, state_nx;
  logic [DELAY_W-1:0]  n_q, n_nx;
  logic                trig_q, trig_nx;
  logic [NUM_LIGHTS-1:0] lights_nx;
  logic [CNT_W-1:0]    light_cnt, cnt_nx;
  logic                busy_nx, done_nx;

  assign delay.n       = n_q;
  assign delay.trigger = trig_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      n_q       <= STEP_N;
      trig_q    <= 1'b0;
      lights    <= '0;
      light_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      n_q       <= n_nx;
      trig_q    <= trig_nx;
      lights    <= lights_nx;
      light_cnt <= cnt_nx;
      busy      <= busy_nx;
      done      <= done_nx;
    end
  end

  // Trigger is only re-raised after time_out is seen low, so any timer latency is tolerated.
  always_comb begin
    state_nx  = state;
    n_nx      = n_q;
    trig_nx   = trig_q;
    lights_nx = lights;
    cnt_nx    = light_cnt;
    done_nx   = 1'b0;

    case (state)
      IDLE: begin
        trig_nx = 1'b0;
        if (start && !delay.time_out) begin
          state_nx  = STEP;
          n_nx      = STEP_N;
          trig_nx   = 1'b1;
          lights_nx = '0;
          cnt_nx    = '0;
        end
      end
      STEP: begin
        trig_nx = 1'b1;
        if (delay.time_out) begin
          lights_nx = (lights << 1) | NUM_LIGHTS'(1);
          cnt_nx    = light_cnt + CNT_W'(1);
          trig_nx   = 1'b0;
          if (light_cnt + CNT_W'(1) == CNT_W'(NUM_LIGHTS)) begin
            state_nx = RAND_REARM;
            n_nx     = clamp_hold(rand_n);
          end else begin
            state_nx = STEP_REARM;
          end
        end
      end
      STEP_REARM: begin
        trig_nx = 1'b0;
        if (!delay.time_out) begin
          state_nx = STEP;
          trig_nx  = 1'b1;
        end
      end
      RAND_REARM: begin
        trig_nx = 1'b0;
        if (!delay.time_out) begin
          state_nx = RAND;
          trig_nx  = 1'b1;
        end
      end
      RAND: begin
        trig_nx = 1'b1;
        if (delay.time_out) begin
          lights_nx = '0;
          trig_nx   = 1'b0;
          done_nx   = 1'b1;
          state_nx  = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
        trig_nx  = 1'b0;
      end
    endcase

    busy_nx = (state_nx != IDLE);
  end

endmodule

// File: tb/tb_ex8_light_sequencer.sv
// Bench for ex8_light_sequencer with a behavioural delay timer and an offset-based timing model.
module tb_ex8_light_sequencer;

  localparam int N = 4;
  localparam int L = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [13:0] rand_n = '0;
  logic [2:0]  lights;
  logic        busy, done;

  int checks = 0;
  int errors = 0;

  ex8_light_sequencer_if dif();

  ex8_light_sequencer #(.STEP_N(14'd4), .NUM_LIGHTS(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .rand_n (rand_n),
    .delay  (dif),
    .lights (lights),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  // Timer: time_out rises N edges after trigger rises, held until trigger drops.
  logic timer_to = 1'b0;
  logic force_to = 1'b0;
  int   tcnt = 0;
  assign dif.time_out = timer_to | force_to;

  always @(posedge clk) begin
    if (dif.trigger !== 1'b1) begin
      tcnt     <= 0;
      timer_to <= 1'b0;
    end else if (!timer_to) begin
      if (tcnt + 1 >= int'(dif.n)) timer_to <= 1'b1;
      tcnt <= tcnt + 1;
    end
  end

  function automatic int t_light(input int i);
    return N + 1 + (i - 1) * (N + 3);
  endfunction

  // Offset k counts edges after the start-sampling edge; outputs sampled 1 time unit after each.
  task automatic run_check(input int r0, input bit hold_start, input bit jitter, input string tag);
    int r, tl, tdone, cnt, k, v;
    bit gap, exp_busy, exp_done, exp_trig;
    logic [2:0] exp_l;
    logic [13:0] exp_n;
    logic prev_trig, prev_to;
    r      = (r0 == 0) ? 1 : r0;
    tl     = t_light(L);
    tdone  = tl + 3 + r;
    rand_n = 14'(r0);
    start  = 1'b1;
    prev_trig = dif.trigger;
    prev_to   = dif.time_out;
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;
    k = 0;
    while (1) begin
      cnt = 0;
      gap = 0;
      for (int i = 1; i <= L; i++) begin
        if (t_light(i) <= k) cnt++;
        if (k == t_light(i) || k == t_light(i) + 1) gap = 1;
      end
      exp_l    = (k < tdone) ? 3'((1 << cnt) - 1) : 3'b000;
      exp_busy = (k < tdone);
      exp_done = (k == tdone);
      exp_trig = (k < tdone) && !gap;
      exp_n    = (k < tl) ? 14'(N) : 14'(r);

      checks++;
      if (lights !== exp_l) begin
        errors++;
        $display("FAIL %s lights k=%0d: got %b expected %b", tag, k, lights, exp_l);
      end
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL %s busy k=%0d: got %b expected %b", tag, k, busy, exp_busy);
      end
      checks++;
      if (done !== exp_done) begin
        errors++;
        $display("FAIL %s done k=%0d: got %b expected %b", tag, k, done, exp_done);
      end
      checks++;
      if (dif.trigger !== exp_trig) begin
        errors++;
        $display("FAIL %s trigger k=%0d: got %b expected %b", tag, k, dif.trigger, exp_trig);
      end
      if (exp_trig) begin
        checks++;
        if (dif.n !== exp_n) begin
          errors++;
          $display("FAIL %s delay_n k=%0d: got %0d expected %0d", tag, k, dif.n, exp_n);
        end
      end
      if (dif.trigger === 1'b1 && prev_trig !== 1'b1) begin
        checks++;
        if (prev_to !== 1'b0) begin
          errors++;
          $display("FAIL %s rearm k=%0d: trigger rose with time_out %b, required 0", tag, k, prev_to);
        end
      end
      prev_trig = dif.trigger;
      prev_to   = dif.time_out;

      if (k == tdone + 1) break;
      if (jitter && k < tl) begin
        v = int'($urandom_range(0, 12));
        rand_n = 14'(v);
        if (k + 1 == tl) begin
          r = (v == 0) ? 1 : v;
          tdone = tl + 3 + r;
        end
      end
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; rand_n = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (lights !== 3'b000 || dif.trigger !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || dif.n !== 14'd4) begin
      errors++;
      $display("FAIL reset: got lights=%b trig=%b busy=%b done=%b n=%0d expected 000 0 0 0 4",
               lights, dif.trigger, busy, done, dif.n);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    run_check(6, 1'b0, 1'b0, "basic");
  endtask

  task automatic test_rand_zero();
    run_check(0, 1'b0, 1'b0, "rand0");
  endtask

  task automatic test_start_held();
    run_check(5, 1'b1, 1'b0, "held1");
    run_check(3, 1'b0, 1'b0, "held2");
  endtask

  task automatic test_reset_midrun();
    rand_n = 14'd6;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= t_light(2); k++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (lights !== 3'b011) begin
      errors++;
      $display("FAIL midrun lights: got %b expected 011", lights);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (lights !== 3'b000 || dif.trigger !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || dif.n !== 14'd4) begin
      errors++;
      $display("FAIL midrun reset: got lights=%b trig=%b busy=%b done=%b n=%0d expected 000 0 0 0 4",
               lights, dif.trigger, busy, done, dif.n);
    end
    @(posedge clk); #1;
    checks++;
    if (dif.time_out !== 1'b0) begin
      errors++;
      $display("FAIL midrun timer: time_out=%b expected 0", dif.time_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_stale_timeout();
    force_to = 1'b1;
    start    = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || dif.trigger !== 1'b0) begin
        errors++;
        $display("FAIL stale idle: got busy=%b trig=%b expected 0 0", busy, dif.trigger);
      end
    end
    force_to = 1'b0;
    #1;
    run_check(int'($urandom_range(0, 9)), 1'b0, 1'b0, "stale");
  endtask

  task automatic test_random();
    int gap;
    for (int n = 0; n < 4; n++) begin
      gap = int'($urandom_range(0, 3));
      repeat (gap) begin
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL random gap busy: got %b expected 0", busy);
        end
      end
      run_check(int'($urandom_range(0, 15)), 1'b0, 1'b1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rand_zero();
    test_start_held();
    test_reset_midrun();
    test_stale_timeout();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
